// File: rtl/cpu_pkg.sv
// Shared CPU definitions: word width, bubble encoding, fetch FSM states, IF/ID record.
package cpu_pkg;

  localparam int unsigned XLEN = 32;

  // sll r0,r0,0
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StPause = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] instr;
    logic            valid;
  } if_id_t;

  // IF/ID contents representing "no instruction"
  function automatic if_id_t if_id_bubble(logic [XLEN-1:0] nop);
    if_id_t b;
    b.pc_plus4 = '0;
    b.instr    = nop;
    b.valid    = 1'b0;
    return b;
  endfunction

endpackage

// File: rtl/pc_register.sv
// Program-counter flop: async reset to RESET_PC, loads pc_d_i when load_i, else holds.
module pc_register
  import cpu_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            load_i,
  input  logic [XLEN-1:0] pc_d_i,
  output logic [XLEN-1:0] pc_o
);

  logic [XLEN-1:0] pc_q;

  // PC state: reset, load or hold
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pc_q <= RESET_PC;
    end else if (load_i) begin
      pc_q <= pc_d_i;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, addresses instruction memory and fills IF/ID.
// Applies stall/redirect from ID and exports one-cycle stall/flush strobes.
// Optional macro FETCH_PERF_CNT_EN adds saturating stall/flush/fetch counters.
module fetch_stage #(
  parameter int unsigned IMEM_DEPTH = 256,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR  = cpu_pkg::NOP_INSTR
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic [31:0] imem_addr_o,
  input  logic [31:0] imem_data_i,
  output logic [31:0] pc_o,
  output logic [31:0] if_id_pc_o,
  output logic [31:0] if_id_instr_o,
  output logic        if_id_valid_o,
  output logic        is_stall_o,
  output logic        is_flush_o,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0] stall_cnt_o,
  output logic [31:0] flush_cnt_o,
  output logic [31:0] fetch_cnt_o,
`endif
  output logic        fetch_err_o
);

  localparam logic [31:0] ImemBytes = 32'(4 * IMEM_DEPTH);

  cpu_pkg::fetch_state_e state_q, state_d;
  cpu_pkg::if_id_t       if_id_q, if_id_d;
  logic                  stall_q, stall_d;
  logic                  flush_q, flush_d;
  logic                  err_q, err_d;
  logic                  pc_load;
  logic [31:0]           pc_q, pc_next, pc_plus4;
  logic [1:0]            unused_redirect_lsb;

  // Word-aligned targets only; the byte offset is dropped
  assign unused_redirect_lsb = redirect_pc_i[1:0];
  assign pc_plus4            = pc_q + 32'd4;

  pc_register #(
    .RESET_PC (RESET_PC)
  ) u_pc_register (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .load_i (pc_load),
    .pc_d_i (pc_next),
    .pc_o   (pc_q)
  );

  // Next state, next PC and IF/ID contents; start_i=0 beats stall beats redirect
  always_comb begin
    state_d = state_q;
    pc_load = 1'b0;
    pc_next = pc_plus4;
    if_id_d = cpu_pkg::if_id_bubble(NOP_INSTR);
    stall_d = 1'b0;
    flush_d = 1'b0;
    err_d   = err_q;
    unique case (state_q)
      cpu_pkg::StIdle: begin
        if (start_i) state_d = cpu_pkg::StRun;
      end
      cpu_pkg::StRun: begin
        if (!start_i) begin
          state_d = cpu_pkg::StPause;
        end else if (stall_i) begin
          // Redirect is dropped; ID re-presents it once the stall clears
          if_id_d = if_id_q;
          stall_d = 1'b1;
        end else if (redirect_i) begin
          pc_load = 1'b1;
          pc_next = {redirect_pc_i[31:2], 2'b00};
          flush_d = 1'b1;
        end else begin
          pc_load = 1'b1;
          if (pc_q < ImemBytes) begin
            if_id_d.pc_plus4 = pc_plus4;
            if_id_d.instr    = imem_data_i;
            if_id_d.valid    = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      cpu_pkg::StPause: begin
        if (start_i) state_d = cpu_pkg::StRun;
      end
      default: state_d = cpu_pkg::StIdle;
    endcase
  end

  // Pipeline register, FSM state and registered strobes
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= cpu_pkg::StIdle;
      if_id_q <= cpu_pkg::if_id_bubble(NOP_INSTR);
      stall_q <= 1'b0;
      flush_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if_id_q <= if_id_d;
      stall_q <= stall_d;
      flush_q <= flush_d;
      err_q   <= err_d;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] stall_cnt_q, flush_cnt_q, fetch_cnt_q;
  logic        fetch_load;

  // A fresh valid capture, not a stall-held one
  assign fetch_load = if_id_d.valid & ~stall_d;

  // Saturating event counters
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
      fetch_cnt_q <= '0;
    end else begin
      if (stall_d && stall_cnt_q != '1) stall_cnt_q <= stall_cnt_q + 32'd1;
      if (flush_d && flush_cnt_q != '1) flush_cnt_q <= flush_cnt_q + 32'd1;
      if (fetch_load && fetch_cnt_q != '1) fetch_cnt_q <= fetch_cnt_q + 32'd1;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
  assign fetch_cnt_o = fetch_cnt_q;
`endif

  assign imem_addr_o   = pc_q;
  assign pc_o          = pc_q;
  assign if_id_pc_o    = if_id_q.pc_plus4;
  assign if_id_instr_o = if_id_q.instr;
  assign if_id_valid_o = if_id_q.valid;
  assign is_stall_o    = stall_q;
  assign is_flush_o    = flush_q;
  assign fetch_err_o   = err_q;

endmodule
